// File: rtl/operand_regfile_if.sv
// Operand store bus: one write port, two read request/response ports and
// the ready flag. clk/rst_n stay plain ports on the design.
//   master : decode side (drives requests, observes ready and read data)
//   slave  : operand store
interface operand_regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd1_en;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd1_data;
  logic              rd1_valid;
  logic              rd2_en;
  logic [ADDR_W-1:0] rd2_addr;
  logic [DATA_W-1:0] rd2_data;
  logic              rd2_valid;

  modport master (
    input  ready, rd1_data, rd1_valid, rd2_data, rd2_valid,
    output wr_en, wr_addr, wr_data, rd1_en, rd1_addr, rd2_en, rd2_addr
  );
  modport slave (
    output ready, rd1_data, rd1_valid, rd2_data, rd2_valid,
    input  wr_en, wr_addr, wr_data, rd1_en, rd1_addr, rd2_en, rd2_addr
  );
endinterface

// File: rtl/operand_regfile.sv
// Operand store: DEPTH x DATA_W words, one write port, two registered read
// ports (1-cycle latency, write-first bypass). After reset a sequencer
// zeroes every entry; ready goes high once the clear is done.
//   clk, rst_n : clock, async active-low reset
//   bus        : operand_regfile_if.slave (requests in, ready/read data out)

// One registered read port. Data holds when idle; valid pulses per request.
module operand_rd_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic                          en,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [DATA_W-1:0]             data,
  output logic                          valid
);
  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (run && en) begin
      valid_d = 1'b1;
      // same-cycle write to the same entry wins over the stored word
      data_d  = (wr_en && (wr_addr == addr)) ? wr_data : mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
endmodule

module operand_regfile #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  operand_regfile_if.slave  bus
);
  localparam int NUM_PORTS = 2;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]                  state_d, state_q;
  logic [ADDR_W-1:0]           cnt_d, cnt_q;
  logic [DEPTH-1:0][DATA_W-1:0] mem_d, mem_q;
  logic                        run;

  assign run = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    if (!run) begin
      mem_d[cnt_q] = '0;
      cnt_d        = cnt_q + 1'b1;
      // last entry cleared on this edge -> accept traffic from the next cycle
      if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
    end else if (bus.wr_en) begin
      mem_d[bus.wr_addr] = bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // storage is not reset; the clear sequencer owns initialisation
  always_ff @(posedge clk) mem_q <= mem_d;

  logic [NUM_PORTS-1:0]             rd_en, rd_valid;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data;

  assign rd_en   = {bus.rd2_en, bus.rd1_en};
  assign rd_addr = {bus.rd2_addr, bus.rd1_addr};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    operand_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run),
      .en      (rd_en[p]),
      .addr    (rd_addr[p]),
      .mem     (mem_q),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .data    (rd_data[p]),
      .valid   (rd_valid[p])
    );
  end

  assign bus.ready     = run;
  assign bus.rd1_data  = rd_data[0];
  assign bus.rd1_valid = rd_valid[0];
  assign bus.rd2_data  = rd_data[1];
  assign bus.rd2_valid = rd_valid[1];
endmodule

// File: tb/tb_operand_regfile.sv
// Randomized + directed bench for operand_regfile against a behavioural model:
// an array of words, an edge counter since reset release, and expected read
// registers.
module tb_operand_regfile;
  localparam int DW = 16, AW = 4, DEP = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  operand_regfile #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk = 0, n_err = 0;

  // model state
  logic [DW-1:0] m [0:DEP-1];
  int            cyc;
  logic [DW-1:0] e_d1, e_d2;
  logic          e_v1, e_v2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic e1, input logic [AW-1:0] a1,
                     input logic e2, input logic [AW-1:0] a2);
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd1_en = e1; bus.rd1_addr = a1;
    bus.rd2_en = e2; bus.rd2_addr = a2;
  endtask

  task automatic idle();
    drv(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // one clock edge with the currently driven inputs, checked against the model
  task automatic step();
    e_v1 = 1'b0;
    e_v2 = 1'b0;
    if (cyc >= DEP) begin
      if (bus.rd1_en) begin
        e_v1 = 1'b1;
        e_d1 = (bus.wr_en && bus.wr_addr == bus.rd1_addr) ? bus.wr_data : m[bus.rd1_addr];
      end
      if (bus.rd2_en) begin
        e_v2 = 1'b1;
        e_d2 = (bus.wr_en && bus.wr_addr == bus.rd2_addr) ? bus.wr_data : m[bus.rd2_addr];
      end
      if (bus.wr_en) m[bus.wr_addr] = bus.wr_data;
    end
    cyc++;
    @(posedge clk); #1;
    chk("ready",     32'(bus.ready),     32'(cyc >= DEP));
    chk("rd1_valid", 32'(bus.rd1_valid), 32'(e_v1));
    chk("rd1_data",  32'(bus.rd1_data),  32'(e_d1));
    chk("rd2_valid", 32'(bus.rd2_valid), 32'(e_v2));
    chk("rd2_data",  32'(bus.rd2_data),  32'(e_d2));
  endtask

  // async reset mid-cycle; outputs must drop without waiting for an edge
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ready), 0);
    chk("rst_v1",    32'(bus.rd1_valid), 0);
    chk("rst_d1",    32'(bus.rd1_data), 0);
    chk("rst_v2",    32'(bus.rd2_valid), 0);
    chk("rst_d2",    32'(bus.rd2_data), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
    e_d1 = '0; e_d2 = '0; e_v1 = 1'b0; e_v2 = 1'b0;
    for (int i = 0; i < DEP; i++) m[i] = '0;
  endtask

  task automatic wait_ready();
    idle();
    for (int i = 0; i < DEP; i++) step();
  endtask

  initial begin
    idle();
    #2;
    do_reset();

    // T1: ready after exactly DEP edges, all entries read back zero
    for (int i = 0; i < DEP; i++) begin
      if (i == DEP - 1) chk("t1_ready_low", 32'(bus.ready), 0);
      step();
    end
    chk("t1_ready_high", 32'(bus.ready), 1);
    for (int i = 0; i < DEP; i++) begin
      drv(1'b0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(DEP - 1 - i));
      step();
    end

    // T2: dual read after two writes
    drv(1'b1, 4'd0, 16'hA935, 1'b0, '0, 1'b0, '0); step();
    drv(1'b1, 4'd1, 16'h7E09, 1'b0, '0, 1'b0, '0); step();
    drv(1'b0, '0, '0, 1'b1, 4'd0, 1'b1, 4'd1); step();
    chk("t2_rd1", 32'(bus.rd1_data), 32'h0000A935);
    chk("t2_rd2", 32'(bus.rd2_data), 32'h00007E09);
    idle(); step();
    chk("t2_v1_drop", 32'(bus.rd1_valid), 0);

    // T3: write-first bypass on both ports
    drv(1'b1, 4'd5, 16'hBEEF, 1'b0, '0, 1'b0, '0); step();
    drv(1'b1, 4'd5, 16'h1234, 1'b1, 4'd5, 1'b1, 4'd5); step();
    chk("t3_byp1", 32'(bus.rd1_data), 32'h00001234);
    chk("t3_byp2", 32'(bus.rd2_data), 32'h00001234);
    drv(1'b0, '0, '0, 1'b1, 4'd5, 1'b0, '0); step();
    chk("t3_later", 32'(bus.rd1_data), 32'h00001234);

    // T4: requests during CLEAR are ignored
    do_reset();
    for (int i = 0; i < DEP; i++) begin
      drv(1'b1, 4'd3, 16'hFFFF, 1'b1, 4'd3, 1'b1, 4'd3);
      step();
    end
    drv(1'b0, '0, '0, 1'b1, 4'd3, 1'b0, '0); step();
    chk("t4_addr3", 32'(bus.rd1_data), 0);

    // T5: reset in RUN loses contents
    drv(1'b1, 4'd15, 16'hC5F6, 1'b0, '0, 1'b0, '0); step();
    drv(1'b0, '0, '0, 1'b1, 4'd15, 1'b0, '0); step();
    chk("t5_pre", 32'(bus.rd1_data), 32'h0000C5F6);
    do_reset();
    wait_ready();
    drv(1'b0, '0, '0, 1'b1, 4'd15, 1'b0, '0); step();
    chk("t5_post", 32'(bus.rd1_data), 0);

    // T6: streaming reads, back-to-back valids
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, AW'(i), DW'(16'h1100 + i * 16'h0101), 1'b0, '0, 1'b0, '0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      drv(1'b0, '0, '0, 1'b1, AW'(i), 1'b0, '0);
      step();
      chk("t6_stream", 32'(bus.rd1_data), 32'(16'h1100 + i * 16'h0101));
    end
    idle(); step();

    // random traffic, biased toward address collisions, with rare resets
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa;
      if ($urandom_range(0, 149) == 0) do_reset();
      wa = AW'($urandom);
      drv(1'($urandom), wa, DW'($urandom),
          1'($urandom), ($urandom_range(0, 3) == 0) ? wa : AW'($urandom),
          1'($urandom), ($urandom_range(0, 3) == 0) ? wa : AW'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/operand_regfile.md
Name: operand_regfile

Overview:
Parametrised successor to the fixed 16x16 operand lookup. It is a clocked operand store with one write port and two independent registered read ports, so operand 1 and operand 2 are fetched in the same cycle. A post-reset clear sequencer zeroes every entry before the store accepts traffic. It sits between the instruction decode stage and the ALU operand inputs.

Parameters:
DATA_W, 16, width of each stored word
DEPTH, 16, number of entries; power of two, minimum 2
ADDR_W, 4, address width; must equal log2(DEPTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
ready  output  1  high when the clear sequence is done and the store accepts requests
wr_en  input  1  write request
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd1_en  input  1  operand 1 read request
rd1_addr  input  ADDR_W  operand 1 address
rd1_data  output  DATA_W  operand 1 value (registered)
rd1_valid  output  1  one-cycle pulse; rd1_data is valid
rd2_en  input  1  operand 2 read request
rd2_addr  input  ADDR_W  operand 2 address
rd2_data  output  DATA_W  operand 2 value (registered)
rd2_valid  output  1  one-cycle pulse; rd2_data is valid

Behaviour:
- Reset (rst_n low, asynchronous): ready=0, rd1_data=0, rd2_data=0, rd1_valid=0, rd2_valid=0, clear counter=0, FSM state=CLEAR. Array contents are don't-care during reset.
- FSM has two states, CLEAR and RUN.
- CLEAR: each cycle writes 0 to entry[counter] and increments counter. After writing entry DEPTH-1, the FSM goes to RUN on the next edge. ready rises exactly DEPTH cycles after rst_n deasserts.
- CLEAR: wr_en, rd1_en and rd2_en are ignored. No array write from the port, valid stays 0, rd*_data holds 0.
- RUN: ready=1. The FSM stays in RUN until reset.
- Write: in RUN with wr_en=1, entry[wr_addr] <= wr_data on the rising edge.
- Read latency is 1 cycle. In RUN with rdN_en=1 at edge k, rdN_data and rdN_valid=1 are presented after edge k.
- rdN_valid is 1 for exactly one cycle per request. Back-to-back enables produce back-to-back valid pulses.
- rdN_data holds its last value when rdN_en=0. Only rdN_valid drops.
- Write-first bypass: if wr_en and rdN_en are both asserted in the same cycle and wr_addr==rdN_addr, rdN_data returns wr_data, not the old contents.
- Both read ports may target the same address in the same cycle. Both return the same word, and the bypass applies to both.
- Addresses wrap naturally in ADDR_W bits, with no out-of-range check.
- Reset asserted mid-operation (in CLEAR or RUN) aborts immediately. The FSM restarts CLEAR from address 0 after rst_n deasserts, and all prior contents are lost.
- No combinational path from any input to any output.

Test Plan:
- Reset, then release → ready=0 for 16 cycles, ready=1 on cycle 16; reads of addresses 0..15 all return 0x0000 with valid one cycle later.
- In RUN, write 0xA935 to addr 0 and 0x7E09 to addr 1, then read rd1 addr 0 and rd2 addr 1 in the same cycle → next cycle rd1_data=0xA935, rd2_data=0x7E09, both valid=1 for one cycle.
- Same-cycle write 0x1234 to addr 5 with rd1 addr 5 and rd2 addr 5 (old value 0xBEEF) → both ports return 0x1234; a later read returns 0x1234.
- Assert wr_en (addr 3, 0xFFFF) and rd1_en during CLEAR → no valid pulse; after ready, addr 3 reads 0x0000.
- Write 0xC5F6 to addr 15, read it, then pulse rst_n low in RUN → outputs are 0 immediately; after the 16-cycle clear, addr 15 reads 0x0000.
- Stream rd1_en high for 8 cycles over addrs 0..7 with distinct data preloaded → 8 consecutive valid cycles, each carrying the data for the matching address with 1-cycle lag.
